// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: per-stage scoreboard behind ID, operand forwarding, load-use stalls,
// decode squash on redirect and a saturating stall counter. Full forwarding is built when FORWARDING_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [ADDR_WIDTH-1:0]        id_rs1,
  input  logic [ADDR_WIDTH-1:0]        id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [ADDR_WIDTH-1:0]        id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_is_load,
  input  logic                         ex_redirect,
  input  logic [STAGES*DATA_WIDTH-1:0] stage_result,
  input  logic [DATA_WIDTH-1:0]        rf_rd1,
  input  logic [DATA_WIDTH-1:0]        rf_rd2,
  output logic [DATA_WIDTH-1:0]        opa,
  output logic [DATA_WIDTH-1:0]        opb,
  output logic                         stall,
  output logic                         flush,
  output logic [CNT_WIDTH-1:0]         stall_count
);

  localparam int SELW = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Bit/row 0 is entry 1 (EX), row STAGES-1 is the writeback entry.
  logic [STAGES-1:0]                 sbValid_q, sbValid_d;
  logic [STAGES-1:0]                 sbWe_q, sbWe_d;
  logic [STAGES-1:0]                 sbLd_q, sbLd_d;
  logic [STAGES-1:0][ADDR_WIDTH-1:0] sbRd_q, sbRd_d;
  logic [CNT_WIDTH-1:0]              stallCount_q, stallCount_d;

  logic [STAGES-1:0] matchA, matchB;
  logic              hazardA, hazardB;

  always_comb begin
    matchA = '0;
    matchB = '0;
    for (int k = 0; k < STAGES; k++) begin
      matchA[k] = id_use_rs1 && (id_rs1 != '0) && sbValid_q[k] && sbWe_q[k] && (sbRd_q[k] == id_rs1);
      matchB[k] = id_use_rs2 && (id_rs2 != '0) && sbValid_q[k] && sbWe_q[k] && (sbRd_q[k] == id_rs2);
    end
  end

`ifdef FORWARDING_EN
  logic [SELW-1:0] selA, selB;
  logic            hitA, hitB, readyA, readyB;

  // Scan oldest to youngest so the youngest matching entry is the one left selected.
  always_comb begin
    hitA = 1'b0;
    hitB = 1'b0;
    selA = '0;
    selB = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (matchA[k]) begin
        hitA = 1'b1;
        selA = SELW'(k);
      end
      if (matchB[k]) begin
        hitB = 1'b1;
        selB = SELW'(k);
      end
    end
    readyA  = !sbLd_q[selA] || ((int'(selA) + 1) >= LOAD_STAGE);
    readyB  = !sbLd_q[selB] || ((int'(selB) + 1) >= LOAD_STAGE);
    hazardA = hitA && !readyA;
    hazardB = hitB && !readyB;
    opa     = (hitA && readyA) ? stage_result[int'(selA)*DATA_WIDTH +: DATA_WIDTH] : rf_rd1;
    opb     = (hitB && readyB) ? stage_result[int'(selB)*DATA_WIDTH +: DATA_WIDTH] : rf_rd2;
  end
`else
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{stage_result, sbLd_q};

  // Without bypassing, only the writeback entry is safe, thanks to the write-first register file.
  always_comb begin
    hazardA = |matchA[STAGES-2:0];
    hazardB = |matchB[STAGES-2:0];
    opa     = rf_rd1;
    opb     = rf_rd2;
  end
`endif

  assign flush       = ex_redirect;
  assign stall       = id_valid && !flush && (hazardA || hazardB);
  assign stall_count = stallCount_q;

  always_comb begin
    sbValid_d    = {sbValid_q[STAGES-2:0], id_valid && !stall && !flush};
    sbWe_d       = {sbWe_q[STAGES-2:0], id_reg_write && (id_rd != '0)};
    sbLd_d       = {sbLd_q[STAGES-2:0], id_is_load};
    sbRd_d       = {sbRd_q[STAGES-2:0], id_rd};
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sbValid_q    <= '0;
      sbWe_q       <= '0;
      sbLd_q       <= '0;
      sbRd_q       <= '0;
      stallCount_q <= '0;
    end else begin
      sbValid_q    <= sbValid_d;
      sbWe_q       <= sbWe_d;
      sbLd_q       <= sbLd_d;
      sbRd_q       <= sbRd_d;
      stallCount_q <= stallCount_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl; expectations follow the FORWARDING_EN build selection.
module tb_pipeline_hazard_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ST = 3;
  localparam int SAT_ST = 8;

  localparam logic [DW-1:0] R1 = 32'h1111_0001;
  localparam logic [DW-1:0] R2 = 32'h2222_0002;
  localparam logic [DW-1:0] S1 = 32'h0000_0011;
  localparam logic [DW-1:0] S2 = 32'h0000_CAFE;
  localparam logic [DW-1:0] S3 = 32'h0000_000B;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                 rst;
  logic                 idValid, idUse1, idUse2, idRegWrite, idIsLoad, exRedirect;
  logic [AW-1:0]        idRs1, idRs2, idRd;
  logic [ST*DW-1:0]     stageResult;
  logic [SAT_ST*DW-1:0] satResult;
  logic [DW-1:0]        rfRd1, rfRd2;
  logic [DW-1:0]        opa, opb, satOpa, satOpb;
  logic                 stall, flush, satStall, satFlush;
  logic [15:0]          stallCount;
  logic [3:0]           satCount;

  pipeline_hazard_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAGES(ST), .LOAD_STAGE(2), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .rst(rst), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_use_rs1(idUse1), .id_use_rs2(idUse2), .id_rd(idRd), .id_reg_write(idRegWrite),
    .id_is_load(idIsLoad), .ex_redirect(exRedirect), .stage_result(stageResult),
    .rf_rd1(rfRd1), .rf_rd2(rfRd2), .opa(opa), .opb(opb), .stall(stall), .flush(flush),
    .stall_count(stallCount)
  );

  pipeline_hazard_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAGES(SAT_ST), .LOAD_STAGE(SAT_ST), .CNT_WIDTH(4)) dutSat (
    .CLK(CLK), .rst(rst), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_use_rs1(idUse1), .id_use_rs2(idUse2), .id_rd(idRd), .id_reg_write(idRegWrite),
    .id_is_load(idIsLoad), .ex_redirect(exRedirect), .stage_result(satResult),
    .rf_rd1(rfRd1), .rf_rd2(rfRd2), .opa(satOpa), .opb(satOpb), .stall(satStall), .flush(satFlush),
    .stall_count(satCount)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
    logic          redir;
    logic [DW-1:0] expOpa;
    logic [DW-1:0] expOpb;
    logic          expStall;
    logic          chkOps;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   expCount = 0;

  // Non-forwarding build always presents the register file and has its own stall column.
  function automatic vec_t mkVec(input logic v, input logic [AW-1:0] rs1, input logic u1,
                                 input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                                 input logic we, input logic ld, input logic redir,
                                 input logic [DW-1:0] opaF, input logic [DW-1:0] opbF,
                                 input logic stallF, input logic stallN, input logic chkF);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.we = we; r.ld = ld; r.redir = redir;
    r.expOpa   = FWD ? opaF : R1;
    r.expOpb   = FWD ? opbF : R2;
    r.expStall = FWD ? stallF : stallN;
    r.chkOps   = FWD ? chkF : 1'b1;
    return r;
  endfunction

  function automatic vec_t idleVec();
    return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 1);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    idValid = v.v; idRs1 = v.rs1; idUse1 = v.u1; idRs2 = v.rs2; idUse2 = v.u2;
    idRd = v.rd; idRegWrite = v.we; idIsLoad = v.ld; exRedirect = v.redir;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    if (v.chkOps) begin
      check({tag, " opa"}, opa, v.expOpa);
      check({tag, " opb"}, opb, v.expOpb);
    end
    check({tag, " stall"}, {31'b0, stall}, {31'b0, v.expStall});
    check({tag, " flush"}, {31'b0, flush}, {31'b0, v.redir});
    check({tag, " stall_count"}, {16'b0, stallCount}, expCount);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    @(negedge CLK);
    checkOutput(v, tag);
    @(posedge CLK);
    #1;
    if (v.expStall) expCount++;
  endtask

  initial begin
    vec_t lw6, cons6, post6, satV;
    stageResult = {S3, S2, S1};
    satResult   = '0;
    rfRd1 = R1;
    rfRd2 = R2;
    rst = 1'b1;
    applyStimulus(idleVec());
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;

    vecs.push_back(idleVec());
    // ALU chain: addi x5 then add reading x5
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 5, 1, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 5, 1, 9, 1, 8, 1, 0, 0, S1, R2, 0, 1, 1));
    repeat (3) vecs.push_back(idleVec());
    // Load-use on rs2, then forwarding from entry 2 and from the writeback entry
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 6, 1, 1, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 1, 6, 1, 10, 1, 0, 0, R1, R2, 1, 1, 0));
    vecs.push_back(mkVec(1, 0, 1, 6, 1, 10, 1, 0, 0, R1, S2, 0, 1, 1));
    vecs.push_back(mkVec(1, 0, 1, 6, 1, 10, 1, 0, 0, R1, S3, 0, 0, 1));
    repeat (3) vecs.push_back(idleVec());
    // Youngest wins: x7 in entries 1 and 3
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 7, 1, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(idleVec());
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 7, 1, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 7, 1, 0, 0, 0, 0, 0, 0, S1, R2, 0, 1, 1));
    repeat (3) vecs.push_back(idleVec());
    // Youngest is an unready load while an older ALU result is ready
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 7, 1, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(idleVec());
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 7, 1, 1, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 7, 1, 0, 0, 0, 0, 0, 0, R1, R2, 1, 1, 0));
    repeat (3) vecs.push_back(idleVec());
    // x0 destination never matches; an unused source never stalls
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 0, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 6, 1, 1, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 6, 0, 0, 0, 0, 0, R1, R2, 0, 0, 1));
    repeat (3) vecs.push_back(idleVec());
    // Flush beats a load-use hazard; the squashed x10 must not appear in entry 1
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 6, 1, 1, 0, R1, R2, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 6, 1, 10, 1, 0, 1, R1, R2, 0, 0, 0));
    vecs.push_back(mkVec(1, 10, 1, 0, 0, 11, 1, 0, 0, R1, R2, 0, 0, 1));
    repeat (3) vecs.push_back(idleVec());

    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while a load-use stall is in progress
    lw6   = mkVec(1, 0, 0, 0, 0, 6, 1, 1, 0, R1, R2, 0, 0, 1);
    cons6 = mkVec(1, 0, 0, 6, 1, 10, 1, 0, 0, R1, R2, 1, 1, 0);
    post6 = mkVec(1, 0, 0, 6, 1, 10, 1, 0, 0, R1, R2, 0, 0, 1);
    runVector(lw6, "rstseq lw");
    applyStimulus(cons6);
    @(negedge CLK);
    checkOutput(cons6, "rstseq stalled");
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    expCount = 0;
    @(negedge CLK);
    checkOutput(post6, "rstseq after");

    // Saturation on the 4-bit counter instance: a self-dependent load held in ID
    rst = 1'b1;
    applyStimulus(idleVec());
    @(posedge CLK);
    #1;
    rst = 1'b0;
    satV = mkVec(1, 6, 1, 0, 0, 6, 1, 1, 0, R1, R2, 0, 0, 1);
    applyStimulus(satV);
    @(negedge CLK);
    check("sat first stall", {31'b0, satStall}, 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("sat stall held", {31'b0, satStall}, 32'd1);
    repeat (7) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("sat ready stall", {31'b0, satStall}, 32'd0);
    check("sat count 7", {28'b0, satCount}, 32'd7);
    repeat (22) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("sat count saturated", {28'b0, satCount}, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
